// File: rtl/mem_map_pkg.sv
// Memory map and shared types for the unified IMEM/DMEM arbiter.
package mem_map_pkg;
  localparam logic [31:0] IMEM_END   = 32'h0000_5000;
  localparam logic [31:0] DMEM_START = 32'h0000_5000;
  localparam logic [31:0] DMEM_END   = 32'h0000_8000;
  localparam int          WORD_BYTES = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  typedef struct packed {
    owner_e own;
    logic   err;
    logic   rd;   // response returns SRAM read data
  } rsp_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and SRAM side of the memory arbiter.
interface mem_arbiter_if #(parameter int MEM_AW = 13);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
           d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_range_check.sv
// Address legality: word alignment plus IMEM window for fetch, DMEM window for data.
module mem_range_check #(
  parameter logic [31:0] IMEM_END   = mem_map_pkg::IMEM_END,
  parameter logic [31:0] DMEM_START = mem_map_pkg::DMEM_START,
  parameter logic [31:0] DMEM_END   = mem_map_pkg::DMEM_END
) (
  input  logic [31:0] addr,
  input  logic        is_data,
  output logic        legal
);
  logic aligned, in_imem, in_dmem;

  assign aligned = (addr[1:0] == 2'b00);
  assign in_imem = (addr < IMEM_END);
  assign in_dmem = (addr >= DMEM_START) && (addr < DMEM_END);
  assign legal   = aligned && (is_data ? in_dmem : in_imem);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: data-over-fetch priority with a starvation guard,
// map/alignment checking and a registered one-cycle response.
module mem_arbiter
  import mem_map_pkg::*;
#(
  parameter logic [31:0] IMEM_END        = mem_map_pkg::IMEM_END,
  parameter logic [31:0] DMEM_START      = mem_map_pkg::DMEM_START,
  parameter logic [31:0] DMEM_END        = mem_map_pkg::DMEM_END,
  parameter int          MEM_AW          = 13,
  parameter int          MAX_DATA_STREAK = 4
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak;
  logic          if_legal, d_legal;
  logic          gnt_if, gnt_d;
  rsp_t          rsp, rsp_nxt;

  mem_range_check #(.IMEM_END(IMEM_END), .DMEM_START(DMEM_START), .DMEM_END(DMEM_END))
    u_chk_if (.addr(bus.if_addr), .is_data(1'b0), .legal(if_legal));
  mem_range_check #(.IMEM_END(IMEM_END), .DMEM_START(DMEM_START), .DMEM_END(DMEM_END))
    u_chk_d  (.addr(bus.d_addr),  .is_data(1'b1), .legal(d_legal));

  // Fetch only overtakes a contending data request once the streak saturates.
  assign gnt_d  = rst_n && bus.d_req && (!bus.if_req || (streak != STREAK_MAX));
  assign gnt_if = rst_n && bus.if_req && !gnt_d;

  assign bus.d_gnt  = gnt_d;
  assign bus.if_gnt = gnt_if;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rsp_nxt       = '{own: OWN_NONE, err: 1'b0, rd: 1'b0};
    if (gnt_d) begin
      rsp_nxt = '{own: OWN_D, err: !d_legal, rd: d_legal && !bus.d_we};
      if (d_legal) begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we ? bus.d_be : 4'b0000;
        bus.mem_addr  = bus.d_addr[MEM_AW+1:2];
        bus.mem_wdata = bus.d_wdata;
      end
    end else if (gnt_if) begin
      rsp_nxt = '{own: OWN_IF, err: !if_legal, rd: if_legal};
      if (if_legal) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr[MEM_AW+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp    <= '{own: OWN_NONE, err: 1'b0, rd: 1'b0};
      streak <= '0;
    end else begin
      rsp <= rsp_nxt;
      if (gnt_if)
        streak <= '0;
      else if (gnt_d && bus.if_req && (streak != STREAK_MAX))
        streak <= streak + 1'b1;
    end
  end

  assign bus.if_rvalid = (rsp.own == OWN_IF);
  assign bus.if_err    = bus.if_rvalid && rsp.err;
  assign bus.if_rdata  = (bus.if_rvalid && rsp.rd) ? bus.mem_rdata : 32'h0;
  assign bus.d_rvalid  = (rsp.own == OWN_D);
  assign bus.d_err     = bus.d_rvalid && rsp.err;
  assign bus.d_rdata   = (bus.d_rvalid && rsp.rd) ? bus.mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte-writable SRAM.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if #(.MEM_AW(13)) bus ();
  mem_arbiter #(.MEM_AW(13), .MAX_DATA_STREAK(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // A pending request must be held until granted.
  logic pend_if, pend_d;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_if <= 1'b0;
      pend_d  <= 1'b0;
    end else begin
      if (pend_if) assert (bus.if_req) else $error("if_req dropped before if_gnt");
      if (pend_d)  assert (bus.d_req)  else $error("d_req dropped before d_gnt");
      pend_if <= bus.if_req && !bus.if_gnt;
      pend_d  <= bus.d_req && !bus.d_gnt;
    end
  end

  task automatic idle_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.d_req = 1'b1;  bus.d_addr = 32'h5000;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err});
    end
    checks++;
    if ({bus.if_rdata, bus.d_rdata, bus.mem_we} !== 68'h0 || dut.streak !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h we=%b streak=%0d exp=0", bus.if_rdata, bus.d_rdata, bus.mem_we, dut.streak);
    end
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b101, 4'b0, 13'd4}) begin
      failures++; $display("FAIL fetch_gnt got=%b%b%b we=%b addr=%h exp=101 0 4", bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    @(posedge clk); #1; bus.if_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.if_rdata} !== {3'b100, 32'h1234_5678}) begin
      failures++; $display("FAIL fetch_rsp got=%b%b%b %h exp=100 12345678", bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.if_rdata);
    end
  endtask

  task automatic test_store_load();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h5004; bus.d_wdata = 32'hAABB_CCDD;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, 4'b0011, 13'h1401, 32'hAABB_CCDD}) begin
      failures++; $display("FAIL store_gnt got=%b%b we=%b addr=%h wd=%h exp=11 0011 1401 aabbccdd", bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk); #1; bus.d_req = 1'b0;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h0}) begin
      failures++; $display("FAIL store_ack got=%b%b %h exp=10 0", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_we} !== 6'b110000) begin
      failures++; $display("FAIL load_gnt got=%b%b we=%b exp=11 0000", bus.d_gnt, bus.mem_en, bus.mem_we);
    end
    @(posedge clk); #1; bus.d_req = 1'b0;
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b10, 32'h1122_CCDD}) begin
      failures++; $display("FAIL load_rsp got=%b%b %h exp=10 1122ccdd", bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
  endtask

  task automatic test_streak();
    int run = 0;
    int max_run = 0;
    logic [1:0] exp_g;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5000;
    for (int i = 0; i < 12; i++) begin
      #1;
      exp_g = (i % 5 == 4) ? 2'b10 : 2'b01;
      checks++;
      if ({bus.if_gnt, bus.d_gnt} !== exp_g) begin
        failures++; $display("FAIL streak_cyc%0d got=%b exp=%b", i, {bus.if_gnt, bus.d_gnt}, exp_g);
      end
      run = bus.d_gnt ? run + 1 : 0;
      if (run > max_run) max_run = run;
      @(negedge clk);
    end
    checks++;
    if (max_run !== 4) begin
      failures++; $display("FAIL streak_max got=%0d exp=4", max_run);
    end
    bus.d_req = 1'b0;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
      failures++; $display("FAIL streak_drain got=%b exp=10", {bus.if_gnt, bus.d_gnt});
    end
    @(posedge clk); #1; bus.if_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_err} !== 3'b100) begin
      failures++; $display("FAIL streak_rsp got=%b exp=100", {bus.if_rvalid, bus.d_rvalid, bus.if_err});
    end
  endtask

  task automatic test_illegal(input bit is_d, input bit we, input logic [31:0] addr, input string name);
    logic [3:0] ram_before;
    @(negedge clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_be = 4'hF; bus.d_addr = addr; bus.d_wdata = 32'hDEAD_BEEF;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    #1;
    ram_before = {is_d ? bus.d_gnt : bus.if_gnt, bus.mem_en, bus.mem_we[1:0] != 2'b00, 1'b0};
    checks++;
    if (ram_before !== 4'b1000) begin
      failures++; $display("FAIL %s_gnt got gnt/en/we=%b exp=1000", name, ram_before);
    end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (is_d ? ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0})
             : ({bus.if_rvalid, bus.if_err, bus.if_rdata} !== {2'b11, 32'h0})) begin
      failures++; $display("FAIL %s_rsp got if=%b%b d=%b%b rd=%h/%h exp=err", name,
                           bus.if_rvalid, bus.if_err, bus.d_rvalid, bus.d_err, bus.if_rdata, bus.d_rdata);
    end
  endtask

  task automatic test_boundary();
    @(negedge clk); bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h7FFC;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_en, bus.mem_addr} !== {2'b11, 13'h1FFF}) begin
      failures++; $display("FAIL bound_d got=%b%b %h exp=11 1fff", bus.d_gnt, bus.mem_en, bus.mem_addr);
    end
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h4FFC;
    #1;
    checks++;
    if ({bus.if_gnt, bus.mem_en, bus.mem_addr} !== {2'b11, 13'h13FF}) begin
      failures++; $display("FAIL bound_if got=%b%b %h exp=11 13ff", bus.if_gnt, bus.mem_en, bus.mem_addr);
    end
    @(posedge clk); #1; idle_inputs();
    checks++;
    if ({bus.if_rvalid, bus.if_err} !== 2'b10) begin
      failures++; $display("FAIL bound_if_rsp got=%b exp=10", {bus.if_rvalid, bus.if_err});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h5008;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
        failures++; $display("FAIL rmid_gnt%0d got=%b exp=01", i, {bus.if_gnt, bus.d_gnt});
      end
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.d_rvalid, bus.if_gnt, bus.mem_en} !== 3'b000 || dut.streak !== '0) begin
      failures++; $display("FAIL rmid_in_reset got=%b streak=%0d exp=000 0", {bus.d_rvalid, bus.if_gnt, bus.mem_en}, dut.streak);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.d_rvalid} !== 4'b1010) begin
      failures++; $display("FAIL rmid_first_fetch got=%b exp=1010", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.d_rvalid});
    end
    @(posedge clk); #1; bus.if_req = 1'b0;
    checks++;
    if ({bus.if_rvalid, bus.d_rvalid} !== 2'b10) begin
      failures++; $display("FAIL rmid_rsp got=%b exp=10", {bus.if_rvalid, bus.d_rvalid});
    end
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) ram[a] = 32'h0;
    ram[4]       = 32'h1234_5678;
    ram[13'h1401] = 32'h1122_3344;
    bus.mem_rdata = 32'h0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_store_load();
    test_streak();
    test_illegal(1'b1, 1'b1, 32'h0000_0100, "st_imem");
    test_illegal(1'b1, 1'b0, 32'h0000_8000, "ld_oob");
    test_illegal(1'b0, 1'b0, 32'h0000_5000, "if_dmem");
    test_illegal(1'b1, 1'b0, 32'h0000_5002, "d_misal");
    test_boundary();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
